bpsk_tx_scheduler: RTL and testbench
====================================

Name: bpsk_tx_scheduler

Overview:
- Sequences the BPSK transmit path and shares it between two packet sources.
- Round-robin arbitration selects one source, latches its packet and prepends a fixed preamble.
- Drives the bit stream and enable into signal_modulator, one bit per modulator symbol strobe.
- Enforces an idle guard gap between packets. Replaces the hard-wired packet_serializer / constant mod_enable path.

Parameters:
PACKET_SIZE, 184, payload bits per packet
PREAMBLE_BITS, 8, preamble length in symbols; must be >= 1
PREAMBLE_PATTERN, 8'hAA, preamble bits sent MSB first; width PREAMBLE_BITS
GAP_CYCLES, 64, clk cycles with mod_enable low after each packet; must be >= 1

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  2  per-source transmit request; level, held until granted
packet_0  input  PACKET_SIZE  source 0 payload; sampled on grant
packet_1  input  PACKET_SIZE  source 1 payload; sampled on grant
sym_next  input  1  one-cycle strobe from modulator at each symbol boundary
grant  output  2  one-hot, one-cycle pulse; the packet is latched that cycle
tx_bit  output  1  current symbol bit to modulator
mod_enable  output  1  high for the whole preamble and payload
busy  output  1  high in any state other than IDLE
active_src  output  1  index of the source being served; holds its last value
tx_done  output  1  one-cycle pulse after the last payload bit is consumed

Behaviour:
- Reset, asynchronous: state IDLE; grant=0, tx_bit=0, mod_enable=0, busy=0, active_src=0, tx_done=0; bit counter=0; round-robin pointer=0, giving source 0 priority first. Reset mid-packet aborts immediately with no tx_done.
- States: IDLE, PREAMBLE, PAYLOAD, GAP.
- IDLE:
  - If req!=0, assert grant for the chosen source in that same cycle.
  - Chosen source: the only requester, or when both request, the source not served last.
  - At the clock edge: latch the packet into a PACKET_SIZE shift register, set active_src, flip the pointer to the other source, clear the counter, go to PREAMBLE.
  - Latency req->grant is 0 cycles when IDLE; req arriving in other states waits.
- PREAMBLE:
  - mod_enable=1; tx_bit = PREAMBLE_PATTERN[PREAMBLE_BITS-1-cnt].
  - Each sym_next increments cnt.
  - On the sym_next with cnt=PREAMBLE_BITS-1: cnt<=0, go to PAYLOAD.
- PAYLOAD:
  - mod_enable=1; tx_bit = shift register MSB, i.e. packet bit PACKET_SIZE-1 first.
  - Each sym_next shifts left by one and increments cnt.
  - On the sym_next with cnt=PACKET_SIZE-1: pulse tx_done next cycle, mod_enable<=0, tx_bit<=0, load the gap counter, go to GAP.
- GAP: mod_enable=0; busy=1; count GAP_CYCLES cycles, then IDLE. No grant is possible during GAP.
- sym_next is ignored in IDLE and GAP. Without sym_next the state and bit hold indefinitely; there is no timeout.
- Changes to packet_x after grant have no effect.
- A req dropped before grant is never served. req held after grant is treated as a new request at the next IDLE.
- Counter width: $clog2(max(PACKET_SIZE,PREAMBLE_BITS,GAP_CYCLES)+1).
- Symbols per packet: exactly PREAMBLE_BITS+PACKET_SIZE sym_next strobes consumed.

Test Plan:
- Reset then req=2'b01, packet_0=184'h5468...6521 (the "This is a test message!" ASCII vector), sym_next every 64 clk:
  - grant=01 in the same cycle.
  - tx_bit sequence = 10101010, then 0101_0100_0110_1000...
  - tx_done after exactly 192 strobes; mod_enable low for 64 cycles; busy falls.
- req=2'b11 held continuously: grants alternate 01,10,01,10; active_src toggles; each grant occurs the first cycle after its GAP ends.
- Source 1 served last, then req=2'b01 only: source 0 granted with no stall. Then req=2'b11: source 1 wins.
- packet_0 changed to all-zeros 3 cycles after grant: the transmitted payload still equals the latched value.
- sym_next pulsed during IDLE and GAP: no bit advance; tx_bit=0, mod_enable=0, counts unchanged.
- rst_n asserted at payload bit 100:
  - All outputs zero asynchronously; no tx_done.
  - After release with req=2'b10, source 1 is granted only if source 0 is not requesting (pointer=0).

Source files
------------

// File: rtl/bpsk_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_tx_scheduler
// Purpose  : Shares the BPSK transmit path between two packet sources.
//            A round-robin arbiter grants one requester, its payload is
//            latched into a shift register, a fixed preamble is sent first,
//            then the payload MSB first, one bit per modulator symbol
//            strobe. An idle guard gap follows every packet.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req[1:0]   - per-source transmit request (level)
//            packet_0/1 - source payloads, sampled on grant
//            sym_next   - symbol-boundary strobe from the modulator
//            grant[1:0] - one-hot grant pulse, packet latched that cycle
//            tx_bit     - current symbol bit to the modulator
//            mod_enable - high through preamble and payload
//            busy       - high whenever not idle
//            active_src - index of the source being served
//            tx_done    - one-cycle pulse after the last payload bit
// Revision : 1.0 - initial release
// ============================================================================
module bpsk_tx_scheduler #(
    parameter int                       PACKET_SIZE      = 184,
    parameter int                       PREAMBLE_BITS    = 8,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = 8'hAA,
    parameter int                       GAP_CYCLES       = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [PACKET_SIZE-1:0] packet_0,
    input  logic [PACKET_SIZE-1:0] packet_1,
    input  logic                   sym_next,
    output logic [1:0]             grant,
    output logic                   tx_bit,
    output logic                   mod_enable,
    output logic                   busy,
    output logic                   active_src,
    output logic                   tx_done
);

    localparam int C_MAX_AB = (PACKET_SIZE > PREAMBLE_BITS) ? PACKET_SIZE : PREAMBLE_BITS;
    localparam int C_MAX    = (C_MAX_AB > GAP_CYCLES) ? C_MAX_AB : GAP_CYCLES;
    localparam int CW       = $clog2(C_MAX + 1);
    localparam int PW       = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;

    localparam logic [CW-1:0] C_PRE_LAST = CW'(PREAMBLE_BITS - 1);
    localparam logic [CW-1:0] C_PAY_LAST = CW'(PACKET_SIZE - 1);
    localparam logic [CW-1:0] C_GAP_LOAD = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREAMBLE = 2'd1;
    localparam logic [1:0] S_PAYLOAD  = 2'd2;
    localparam logic [1:0] S_GAP      = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [CW-1:0]          r_cnt;
    logic [PACKET_SIZE-1:0] r_shift;
    logic                   r_rr_ptr;
    logic                   r_active_src;
    logic                   r_tx_done;
    logic                   w_req_any;
    logic                   w_sel;
    logic [CW-1:0]          w_pre_off;
    logic [PW-1:0]          w_pre_idx;

    assign w_req_any = |req;
    // Single requester wins outright; on contention the pointer names the
    // source that was not served last.
    assign w_sel     = (req == 2'b11) ? r_rr_ptr : req[1];

    // Preamble bits go out MSB first, so the pattern index counts down.
    assign w_pre_off = C_PRE_LAST - r_cnt;
    assign w_pre_idx = w_pre_off[PW-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_next_state = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (sym_next && (r_cnt == C_PRE_LAST)) begin
                    w_next_state = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (sym_next && (r_cnt == C_PAY_LAST)) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shared counter, payload shift register, arbiter pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_rr_ptr     <= 1'b0;
            r_active_src <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_shift      <= w_sel ? packet_1 : packet_0;
                        r_active_src <= w_sel;
                        r_rr_ptr     <= ~w_sel;
                        r_cnt        <= '0;
                    end
                end
                S_PREAMBLE: begin
                    if (sym_next) begin
                        r_cnt <= (r_cnt == C_PRE_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    if (sym_next) begin
                        r_shift <= {r_shift[PACKET_SIZE-2:0], 1'b0};
                        if (r_cnt == C_PAY_LAST) begin
                            // Counter is reused to time the guard gap.
                            r_cnt     <= C_GAP_LOAD;
                            r_tx_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        grant      = 2'b00;
        tx_bit     = 1'b0;
        mod_enable = 1'b0;
        busy       = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                // Gated by rst_n so the grant stays low while held in reset.
                if (rst_n && w_req_any) begin
                    grant = w_sel ? 2'b10 : 2'b01;
                end
            end
            S_PREAMBLE: begin
                mod_enable = 1'b1;
                tx_bit     = PREAMBLE_PATTERN[w_pre_idx];
            end
            S_PAYLOAD: begin
                mod_enable = 1'b1;
                tx_bit     = r_shift[PACKET_SIZE-1];
            end
            S_GAP: begin
                mod_enable = 1'b0;
            end
            default: begin
                mod_enable = 1'b0;
            end
        endcase
    end

    assign active_src = r_active_src;
    assign tx_done    = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpsk_tx_scheduler
// Purpose  : Self-checking bench for bpsk_tx_scheduler. The driver issues
//            requests, payloads and symbol strobes; a reference model
//            decides each grant from the arbitration rule, queues the
//            preamble+payload bits it expects, and a negedge monitor
//            compares every cycle of DUT output against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpsk_tx_scheduler;

    localparam int PS  = 184;
    localparam int PB  = 8;
    localparam int GAP = 64;
    localparam logic [PB-1:0] PRE = 8'hAA;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [PS-1:0] packet_0;
    logic [PS-1:0] packet_1;
    logic          sym_next;
    logic [1:0]    grant;
    logic          tx_bit;
    logic          mod_enable;
    logic          busy;
    logic          active_src;
    logic          tx_done;

    bpsk_tx_scheduler #(
        .PACKET_SIZE     (PS),
        .PREAMBLE_BITS   (PB),
        .PREAMBLE_PATTERN(PRE),
        .GAP_CYCLES      (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .packet_0  (packet_0),
        .packet_1  (packet_1),
        .sym_next  (sym_next),
        .grant     (grant),
        .tx_bit    (tx_bit),
        .mod_enable(mod_enable),
        .busy      (busy),
        .active_src(active_src),
        .tx_done   (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PS-1:0] rand_pkt();
        logic [191:0] t;
        for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
        return t[PS-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Symbol strobe generator: 0 = off, 1 = every 64 clocks, 2 = random.
    // Runs in every state so strobes also land in IDLE and GAP.
    // ------------------------------------------------------------------
    int sym_mode = 0;
    int sym_div  = 0;
    initial begin
        sym_next = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sym_mode == 1) begin
                sym_div  = (sym_div == 63) ? 0 : sym_div + 1;
                sym_next = (sym_div == 0);
            end else if (sym_mode == 2) begin
                sym_next = 1'($urandom_range(0, 1));
            end else begin
                sym_next = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model + monitor (sampled on the falling edge)
    //   phase 0: idle, 1: sending queued bits, 2: guard gap
    // ------------------------------------------------------------------
    int            m_phase = 0;
    logic          m_last  = 1'b1;   // "served last" = 1 gives source 0 first priority
    logic          m_active = 1'b0;
    int            m_gap   = 0;
    logic          exp_q[$];
    logic [1:0]    glog[$];
    int            mon_sym_cnt = 0;
    logic [191:0]  rx_log = '0;
    logic [6:0]    m_act;
    logic [6:0]    m_exp;
    logic [1:0]    m_eg;
    logic          m_win;
    logic [PS-1:0] m_pkt;

    always @(negedge clk) begin
        m_act = {grant, busy, mod_enable, tx_done, tx_bit, active_src};
        if (!rst_n) begin
            chk("reset_outputs", 32'(m_act), 32'd0);
            m_phase     = 0;
            m_last      = 1'b1;
            m_active    = 1'b0;
            exp_q.delete();
            mon_sym_cnt = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_eg  = 2'b00;
                    m_win = 1'b0;
                    if (req != 2'b00) begin
                        m_win = (req == 2'b11) ? ~m_last : req[1];
                        m_eg  = m_win ? 2'b10 : 2'b01;
                    end
                    m_exp = {m_eg, 1'b0, 1'b0, 1'b0, 1'b0, m_active};
                    chk("idle_cycle", 32'(m_act), 32'(m_exp));
                    if (req != 2'b00) begin
                        m_pkt = m_win ? packet_1 : packet_0;
                        for (int i = PB - 1; i >= 0; i--) exp_q.push_back(PRE[i]);
                        for (int i = PS - 1; i >= 0; i--) exp_q.push_back(m_pkt[i]);
                        m_last      = m_win;
                        m_active    = m_win;
                        m_phase     = 1;
                        mon_sym_cnt = 0;
                        glog.push_back(m_eg);
                    end
                end
                1: begin
                    m_exp = {2'b00, 1'b1, 1'b1, 1'b0, exp_q[0], m_active};
                    chk("tx_cycle", 32'(m_act), 32'(m_exp));
                    if (sym_next) begin
                        void'(exp_q.pop_front());
                        mon_sym_cnt++;
                        rx_log = {rx_log[190:0], tx_bit};
                        if (exp_q.size() == 0) begin
                            m_phase = 2;
                            m_gap   = GAP;
                        end
                    end
                end
                default: begin
                    m_exp = {2'b00, 1'b1, 1'b0, (m_gap == GAP), 1'b0, m_active};
                    chk("gap_cycle", 32'(m_act), 32'(m_exp));
                    if (tx_done) chk("symbols_per_packet", 32'(mon_sym_cnt), 32'(PB + PS));
                    m_gap--;
                    if (m_gap == 0) m_phase = 0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (bounded waits)
    // ------------------------------------------------------------------
    task automatic wait_grant();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 2'b00 && n < 5000);
        chk("grant_seen", 32'(grant != 2'b00), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 20000);
        chk("idle_reached", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    localparam logic [PS-1:0] MSG = "This is a test message!";
    localparam logic [1:0] EXP_G [11] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10,
                                          2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

    initial begin
        int n;
        logic [191:0] exp_log;
        rst_n    = 1'b0;
        req      = 2'b00;
        packet_0 = '0;
        packet_1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Source 0 alone, message vector, one strobe every 64 clocks.
        packet_0 = MSG;
        sym_mode = 1;
        req      = 2'b01;
        wait_grant();
        req = 2'b00;
        wait_idle();
        exp_log = {PRE, MSG};
        checks++;
        if (rx_log !== exp_log) begin
            errors++;
            $display("FAIL message_bits: got %h expected %h", rx_log, exp_log);
        end

        // Source 1 alone, payload changed after grant.
        sym_mode = 2;
        packet_1 = rand_pkt();
        req      = 2'b10;
        wait_grant();
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        packet_1 = rand_pkt();
        wait_idle();

        // Both requesting continuously: four alternating grants.
        packet_0 = rand_pkt();
        packet_1 = rand_pkt();
        req      = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_grant();
            if (i == 0) begin
                repeat (2) @(posedge clk);
                #1;
                packet_0 = '0;
            end else begin
                packet_0 = rand_pkt();
                packet_1 = rand_pkt();
            end
            if (i == 3) req = 2'b01;
        end

        // Source 1 served last: lone source 0 goes first, then contention
        // favours source 1.
        wait_grant();
        req = 2'b11;
        wait_grant();
        req = 2'b00;
        wait_idle();

        // Reset in the middle of the payload.
        packet_0 = rand_pkt();
        req      = 2'b01;
        wait_grant();
        req = 2'b00;
        n = 0;
        while (mon_sym_cnt < PB + 100 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("reached_payload_bit_100", 32'(mon_sym_cnt), 32'(PB + 100));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            32'({grant, busy, mod_enable, tx_done, tx_bit, active_src}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        packet_0 = rand_pkt();
        packet_1 = rand_pkt();
        req      = 2'b11;
        wait_grant();
        req = 2'b00;
        wait_idle();
        req = 2'b10;
        wait_grant();
        req = 2'b00;
        wait_idle();
        repeat (5) @(posedge clk);

        chk("grant_count", 32'(glog.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < glog.size()) chk("grant_order", 32'(glog[i]), 32'(EXP_G[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
